unary_add_seq: RTL and testbench
================================

Name: unary_add_seq

Overview:
Sequencer that sits upstream and downstream of the unary adder stage and drives a complete operation. It accepts two binary operands over a valid/ready handshake and serialises them into unary bit streams on the adder's A/B inputs during the read phase. It then switches the adder to write phase, counts the unary result back into binary, and captures the adder's carry pulse. It presents {sum, carry} on an output valid/ready handshake.

Parameters:
WIDTH, 4, operand/result width; must match the adder's internal counter width
SETTLE_CYC, 2, read-phase idle cycles after feeding so the adder's flag-to-C pipeline completes

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept operands
in_a  in  WIDTH  operand A, binary
in_b  in  WIDTH  operand B, binary
add_en  out  1  to adder en
add_rw  out  1  to adder read_or_write (0 = read/accumulate, 1 = write/drain)
add_a  out  1  to adder A (unary stream)
add_b  out  1  to adder B (unary stream)
add_dout  in  1  from adder dout (unary result stream)
add_c  in  1  from adder C (carry pulse)
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_sum  out  WIDTH  binary count of unary result
res_carry  out  1  adder raised C during this operation

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1.
  - All add_* outputs, res_valid, res_sum and res_carry = 0.
  - All internal counters = 0.
- Every output is registered, with one exception: in_ready = (state==IDLE), decoded from the state register.
- IDLE:
  - add_en=0, add_a=add_b=0.
  - On in_valid&&in_ready: latch a_cnt=in_a and b_cnt=in_b, clear the sum and carry accumulators, go to FEED.
- FEED (add_en=1, add_rw=0):
  - Each cycle drive add_a=(a_cnt!=0) and add_b=(b_cnt!=0).
  - Decrement each counter that is nonzero.
  - Lasts max(in_a,in_b) cycles. With both operands 0, FEED lasts 0 cycles and the sequencer goes straight to SETTLE.
- SETTLE (add_en=1, add_rw=0, add_a=add_b=0): lasts SETTLE_CYC cycles, then go to DRAIN.
- DRAIN (add_en=1, add_rw=1, add_a=add_b=0):
  - Lasts 2^WIDTH+1 cycles; this covers the adder's one-cycle registered dout latency plus full counter depletion.
  - Sum accumulator increments each DRAIN cycle in which add_dout=1. It is WIDTH bits wide and never exceeds 2^WIDTH-1.
  - The adder counter is guaranteed 0 at DRAIN exit, so no residue carries into the next operation.
  - Then go to DONE.
- Carry capture: the carry accumulator is set if add_c=1 in any cycle of FEED, SETTLE or DRAIN.
- DONE (add_en=0):
  - res_valid=1; res_sum and res_carry hold the accumulated values, stable while res_valid && !res_ready.
  - On res_ready: res_valid=0, go to IDLE.
  - res_sum/res_carry keep their last value until the next operation completes.
- Latency, accept to res_valid: max(a,b) + SETTLE_CYC + 2^WIDTH + 1 + 1 cycles. Back-to-back ops: the earliest next accept is the cycle after the result handshake.
- Arithmetic: res_sum = (a+b) mod 2^WIDTH, as held by the adder counter. res_carry=1 iff a+b crossed the adder threshold (2^WIDTH-2 for WIDTH=4, i.e. 14).
- in_a/in_b are sampled only at accept; later changes are ignored.
- Reset mid-operation: the sequencer returns to IDLE immediately and drives add_en=0. The adder must be reset by the same system reset event. The sequencer does not clear adder state itself.
- No pipelining: one operation in flight.

Test Plan:
- Reset, then a=5, b=6 accepted; hold res_ready=1 -> 6 FEED cycles (a,b pulses 5/6), res_valid after 6+2+17+1 = 26 cycles, res_sum=11, res_carry=0.
- a=7, b=7 -> res_sum=14, res_carry=1; add_c observed exactly once.
- a=0, b=0 -> FEED skipped, res_valid after 20 cycles, res_sum=0, res_carry=0, add_a/add_b never high.
- a=13, b=1 then a=2, b=3 back-to-back with res_ready held low 5 cycles on the first -> first result {14,1} stable 5 cycles; in_ready=0 until handshake; second result {5,0} with no residue.
- a=15, b=0 -> res_sum=15, res_carry=1 (crosses 14); DRAIN counts exactly 15 dout ones.
- Assert rst during DRAIN of a=9, b=4 (adder also reset) -> all outputs 0 asynchronously, in_ready=1 next cycle; a new a=3, b=3 op then yields {6,0}.

Source files
------------

// File: rtl/unary_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : unary_add_seq                                                   |
// | Brief    : Serialises binary operands into unary streams for the adder,    |
// |            drains the unary result back to binary and captures the carry.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module unary_add_seq #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 2   // must be at least 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_en,
  output logic             add_rw,
  output logic             add_a,
  output logic             add_b,
  input  logic             add_dout,
  input  logic             add_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry
);

  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [2:0] C_S_IDLE   = 3'd0;
  localparam logic [2:0] C_S_FEED   = 3'd1;
  localparam logic [2:0] C_S_SETTLE = 3'd2;
  localparam logic [2:0] C_S_DRAIN  = 3'd3;
  localparam logic [2:0] C_S_DONE   = 3'd4;

  localparam logic [WIDTH-1:0] C_ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SCW-1:0]   C_SETTLE_ONE  = {{(SCW-1){1'b0}}, 1'b1};
  localparam logic [SCW-1:0]   C_SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [WIDTH:0]   C_DRAIN_ONE   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   C_DRAIN_LAST  = {1'b1, {WIDTH{1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_cnt_q, a_cnt_d;
  logic [WIDTH-1:0] b_cnt_q, b_cnt_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [WIDTH:0]   drain_cnt_q, drain_cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             add_en_q, add_en_d;
  logic             add_rw_q, add_rw_d;
  logic             add_a_q, add_a_d;
  logic             add_b_q, add_b_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_carry_q, res_carry_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= C_S_IDLE;
      a_cnt_q      <= '0;
      b_cnt_q      <= '0;
      settle_cnt_q <= '0;
      drain_cnt_q  <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      add_en_q     <= 1'b0;
      add_rw_q     <= 1'b0;
      add_a_q      <= 1'b0;
      add_b_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_cnt_q      <= a_cnt_d;
      b_cnt_q      <= b_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      add_en_q     <= add_en_d;
      add_rw_q     <= add_rw_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      res_valid_q  <= res_valid_d;
      res_sum_q    <= res_sum_d;
      res_carry_q  <= res_carry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_cnt_d      = a_cnt_q;
    b_cnt_d      = b_cnt_q;
    settle_cnt_d = settle_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    unique case (state_q)
      C_S_IDLE: begin
        if (in_valid) begin
          a_cnt_d      = in_a;
          b_cnt_d      = in_b;
          sum_d        = '0;
          carry_d      = 1'b0;
          settle_cnt_d = '0;
          drain_cnt_d  = '0;
          state_d      = ((in_a != '0) || (in_b != '0)) ? C_S_FEED : C_S_SETTLE;
        end
      end
      C_S_FEED: begin
        carry_d = carry_q | add_c;
        if (a_cnt_q != '0) a_cnt_d = a_cnt_q - C_ONE;
        if (b_cnt_q != '0) b_cnt_d = b_cnt_q - C_ONE;
        // Leave once both streams will have emitted their final pulse.
        if ((a_cnt_q <= C_ONE) && (b_cnt_q <= C_ONE)) begin
          state_d      = C_S_SETTLE;
          settle_cnt_d = '0;
        end
      end
      C_S_SETTLE: begin
        carry_d = carry_q | add_c;
        if (settle_cnt_q == C_SETTLE_LAST) begin
          state_d     = C_S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + C_SETTLE_ONE;
        end
      end
      C_S_DRAIN: begin
        carry_d = carry_q | add_c;
        sum_d   = sum_q + {{(WIDTH-1){1'b0}}, add_dout};
        if (drain_cnt_q == C_DRAIN_LAST) begin
          state_d = C_S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + C_DRAIN_ONE;
        end
      end
      C_S_DONE: begin
        if (res_ready) state_d = C_S_IDLE;
      end
      default: state_d = C_S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with state_q.
  always_comb begin
    add_en_d    = (state_d == C_S_FEED) || (state_d == C_S_SETTLE) || (state_d == C_S_DRAIN);
    add_rw_d    = (state_d == C_S_DRAIN);
    add_a_d     = (state_d == C_S_FEED) && (a_cnt_d != '0);
    add_b_d     = (state_d == C_S_FEED) && (b_cnt_d != '0);
    res_valid_d = (state_d == C_S_DONE);
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    if ((state_q == C_S_DRAIN) && (state_d == C_S_DONE)) begin
      res_sum_d   = sum_d;
      res_carry_d = carry_d;
    end
  end

  assign in_ready  = (state_q == C_S_IDLE);
  assign add_en    = add_en_q;
  assign add_rw    = add_rw_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;

endmodule
`default_nettype wire

// File: tb/tb_unary_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_unary_add_seq                                                |
// | Brief    : Scoreboard bench for unary_add_seq with a behavioural adder.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_unary_add_seq;

  localparam int WIDTH = 4;
  localparam int THRESH = (1 << WIDTH) - 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             add_en, add_rw, add_a, add_b, add_dout, add_c;
  logic             res_valid, res_ready, res_carry;
  logic [WIDTH-1:0] res_sum;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int n_a = 0, n_b = 0, n_c = 0, n_d = 0;

  always #5 clk = ~clk;

  unary_add_seq #(.WIDTH(WIDTH), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_en(add_en), .add_rw(add_rw), .add_a(add_a), .add_b(add_b),
    .add_dout(add_dout), .add_c(add_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_carry(res_carry)
  );

  // Behavioural unary adder: accumulates pulses, flags the threshold crossing
  // (C one cycle after), and drains through a registered dout.
  logic [WIDTH-1:0] m_cnt;
  logic             m_pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt    <= '0;
      m_pend   <= 1'b0;
      add_c    <= 1'b0;
      add_dout <= 1'b0;
    end else begin
      add_c    <= m_pend;
      m_pend   <= 1'b0;
      add_dout <= 1'b0;
      if (add_en && !add_rw) begin
        int tot;
        tot = int'(m_cnt) + int'(add_a) + int'(add_b);
        if (int'(m_cnt) < THRESH && tot >= THRESH) m_pend <= 1'b1;
        m_cnt <= WIDTH'(tot);
      end else if (add_en && add_rw) begin
        add_dout <= (m_cnt != '0);
        if (m_cnt != '0) m_cnt <= m_cnt - 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (add_en && add_a) n_a <= n_a + 1;
    if (add_en && add_b) n_b <= n_b + 1;
    if (add_c) n_c <= n_c + 1;
    if (add_rw && add_dout) n_d <= n_d + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    int   n, w, busy, unstable;
    int   pa0, pb0, pc0, pd0;
    int   s0, c0;
    exp_t e;
    exp_t got_e;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", int'(in_ready), 1);
    pa0 = n_a; pb0 = n_b; pc0 = n_c; pd0 = n_d;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    res_ready = (hold == 0);
    e.sum   = WIDTH'(int'(a) + int'(b));
    e.carry = (int'(a) + int'(b)) >= THRESH;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    n    = 1;
    busy = 0;
    forever begin
      @(negedge clk);
      if (res_valid || n >= 200) break;
      if (in_ready) busy++;
      @(posedge clk);
      n++;
    end
    check("latency", n, ((a > b) ? int'(a) : int'(b)) + 20);
    check("busy_in_ready", busy, 0);
    check("a_pulses", n_a - pa0, int'(a));
    check("b_pulses", n_b - pb0, int'(b));
    check("c_pulses", n_c - pc0, int'(e.carry));
    check("dout_ones", n_d - pd0, int'(e.sum));
    s0 = int'(res_sum);
    c0 = int'(res_carry);
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      if (res_valid !== 1'b1 || int'(res_sum) != s0 || int'(res_carry) != c0 || in_ready)
        unstable++;
      @(negedge clk);
    end
    if (hold > 0) check("hold_stable", unstable, 0);
    res_ready = 1'b1;
    check("res_valid", int'(res_valid), 1);
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      got_e = sb.pop_front();
      check("res_sum", int'(res_sum), int'(got_e.sum));
      check("res_carry", int'(res_carry), int'(got_e.carry));
    end
    @(negedge clk);
    check("valid_drop", int'(res_valid), 0);
    check("sum_keep", int'(res_sum), int'(e.sum));
    check("in_ready_after", int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_add_bus", int'({add_en, add_rw, add_a, add_b}), 0);
    check("rst_res", int'({res_valid, res_sum, res_carry}), 0);
    rst = 1'b0;

    run_op(4'd5, 4'd6, 0);
    run_op(4'd7, 4'd7, 0);
    run_op(4'd0, 4'd0, 0);
    run_op(4'd13, 4'd1, 5);
    run_op(4'd2, 4'd3, 0);
    run_op(4'd15, 4'd0, 0);

    // Reset in the middle of DRAIN
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 4'd9;
    in_b     = 4'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    w = 0;
    while (!add_rw && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("reached_drain", int'(add_rw), 1);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_add_bus", int'({add_en, add_rw, add_a, add_b}), 0);
    check("arst_res", int'({res_valid, res_sum, res_carry}), 0);
    check("arst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    run_op(4'd3, 4'd3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
